ordered_collector: RTL and testbench

Parametrised successor to the fixed two-channel collector. Gathers encrypted words from `NUM_CH` encrypter lanes in strict round-robin order (lane 0, 1, … `NUM_CH-1`, 0, …) and serialises each word MSB-first onto a `BUS_W`-bit QSPI-style output with ready backpressure. It adds three things the fixed version lacks: zero-bubble back-to-back words, a short final word via `tail_beats`, and an end-of-stream `done` pulse. It sits between the encrypter array and the top-level output pins.

---
 rtl/ordered_collector.sv | 184 ++++++++++++++++++
 tb/tb_ordered_collector.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ordered_collector.sv
// ordered_collector
//
// Collects encrypted words from NUM_CH encrypter lanes in strict round-robin
// order and serialises each word MSB-first onto a BUS_W-bit QSPI-style bus
// with ready backpressure. Back-to-back words from consecutive lanes stream
// with no idle cycle between them. A word flagged as last may be shortened
// with tail_beats and is followed by a one-cycle done pulse, after which
// collection restarts from lane 0.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   ch_data        lane words, lane c at [c*WORD_W +: WORD_W]
//   ch_data_ready  per-lane "word valid"
//   ch_last        per-lane "current word ends the stream"
//   tail_beats     beat count for a last word (0 or > BEATS means BEATS)
//   ch_capture     one-hot, one-cycle "word taken" pulse back to the lane
//   qspi_data      current output beat
//   qspi_sending   qspi_data is valid
//   qspi_ready     sink accepts the current beat on this edge
//   done           one-cycle pulse after the final beat of a last word
//   busy           collector is not idle in WAIT
module ordered_collector #(
  parameter int NUM_CH = 2,
  parameter int WORD_W = 32,
  parameter int BUS_W  = 4,
  parameter int TB_W   = $clog2((WORD_W / BUS_W) + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*WORD_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_data_ready,
  input  logic [NUM_CH-1:0]        ch_last,
  input  logic [TB_W-1:0]          tail_beats,
  output logic [NUM_CH-1:0]        ch_capture,
  output logic [BUS_W-1:0]         qspi_data,
  output logic                     qspi_sending,
  input  logic                     qspi_ready,
  output logic                     done,
  output logic                     busy
);

  localparam int BEATS = WORD_W / BUS_W;
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [TB_W-1:0]  BEATS_TB = TB_W'(BEATS);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [PTR_W-1:0]  ptr, ptr_next;
  logic [WORD_W-1:0] shreg, shreg_next;
  logic [TB_W-1:0]   beats_left, beats_left_next;
  logic              is_last, is_last_next;
  logic [NUM_CH-1:0] capture_next;

  logic [PTR_W-1:0]  ptr_inc;
  logic [PTR_W-1:0]  cand_ptr;
  logic [WORD_W-1:0] sel_word;
  logic              sel_ready;
  logic              sel_last;
  logic              sel_captured;
  logic [TB_W-1:0]   tail_eff;
  logic              final_beat;
  logic              do_load;

  // The lane that could be loaded this cycle: the current pointer while
  // idle, or the following lane while a word is shifting out, so that the
  // next word can be picked up on the same edge as the final beat.
  always_comb begin
    ptr_inc  = (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    cand_ptr = (state == ST_SHIFT) ? ptr_inc : ptr;
  end

  // Lane multiplexer for the candidate lane. The capture term blocks a
  // second take of a word whose lane has not yet reacted to ch_capture,
  // which only matters when the candidate lane is the one just loaded.
  always_comb begin
    sel_word     = '0;
    sel_ready    = 1'b0;
    sel_last     = 1'b0;
    sel_captured = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cand_ptr == PTR_W'(c)) begin
        sel_word     = ch_data[c*WORD_W +: WORD_W];
        sel_ready    = ch_data_ready[c];
        sel_last     = ch_last[c];
        sel_captured = ch_capture[c];
      end
    end
  end

  // Out-of-range tail counts fall back to a full word.
  always_comb begin
    tail_eff = tail_beats;
    if ((tail_beats == '0) || (tail_beats > BEATS_TB)) begin
      tail_eff = BEATS_TB;
    end
  end

  // State register and all datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_WAIT;
      ptr        <= '0;
      shreg      <= '0;
      beats_left <= '0;
      is_last    <= 1'b0;
      ch_capture <= '0;
    end else begin
      state      <= state_next;
      ptr        <= ptr_next;
      shreg      <= shreg_next;
      beats_left <= beats_left_next;
      is_last    <= is_last_next;
      ch_capture <= capture_next;
    end
  end

  // Next-state logic. A load can come from WAIT or from the final beat of a
  // non-last word; in both cases the load overrides the shift of shreg.
  always_comb begin
    state_next      = state;
    ptr_next        = ptr;
    shreg_next      = shreg;
    beats_left_next = beats_left;
    is_last_next    = is_last;
    capture_next    = '0;
    do_load         = 1'b0;
    final_beat      = qspi_ready && (beats_left == TB_W'(1));

    case (state)
      ST_WAIT: begin
        do_load = sel_ready && !sel_captured;
      end
      ST_SHIFT: begin
        if (qspi_ready) begin
          shreg_next      = shreg << BUS_W;
          beats_left_next = beats_left - 1'b1;
          if (final_beat) begin
            if (is_last) begin
              state_next = ST_DONE;
              ptr_next   = '0;
            end else begin
              ptr_next   = ptr_inc;
              state_next = ST_WAIT;
              do_load    = sel_ready && !sel_captured;
            end
          end
        end
      end
      ST_DONE: begin
        state_next = ST_WAIT;
      end
      default: begin
        state_next = ST_WAIT;
      end
    endcase

    if (do_load) begin
      shreg_next      = sel_word;
      beats_left_next = sel_last ? tail_eff : BEATS_TB;
      is_last_next    = sel_last;
      state_next      = ST_SHIFT;
      for (int c = 0; c < NUM_CH; c++) begin
        capture_next[c] = (cand_ptr == PTR_W'(c));
      end
    end
  end

  // Outputs decode registered state only; nothing here depends on
  // qspi_ready.
  always_comb begin
    qspi_sending = (state == ST_SHIFT);
    qspi_data    = qspi_sending ? shreg[WORD_W-1 -: BUS_W] : '0;
    done         = (state == ST_DONE);
    busy         = (state != ST_WAIT);
  end

endmodule

// File: tb/tb_ordered_collector.sv
// Directed testbench for ordered_collector. A two-lane 32/4 instance covers
// reset, ordered bursts, order enforcement, backpressure, mid-word reset and
// tail/done handling; a three-lane 32/8 and a single-lane 32/4 instance
// cover the parameter sweep.
module tb_ordered_collector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Two-lane instance, 32-bit words, 4-bit bus
  logic [63:0] ch_data;
  logic [1:0]  ch_data_ready;
  logic [1:0]  ch_last;
  logic [3:0]  tail_beats;
  logic [1:0]  ch_capture;
  logic [3:0]  qspi_data;
  logic        qspi_sending;
  logic        qspi_ready;
  logic        done;
  logic        busy;

  // Three-lane instance, 32-bit words, 8-bit bus
  logic [95:0] d3_data;
  logic [2:0]  d3_ready;
  logic [2:0]  d3_last;
  logic [2:0]  d3_tail;
  logic [2:0]  d3_cap;
  logic [7:0]  d3_q;
  logic        d3_sending;
  logic        d3_qready;
  logic        d3_done;
  logic        d3_busy;

  // Single-lane instance, 32-bit words, 4-bit bus
  logic [31:0] d1_data;
  logic        d1_ready;
  logic        d1_last;
  logic [3:0]  d1_tail;
  logic        d1_cap;
  logic [3:0]  d1_q;
  logic        d1_sending;
  logic        d1_qready;
  logic        d1_done;
  logic        d1_busy;

  int checks = 0;
  int errors = 0;

  ordered_collector #(.NUM_CH(2), .WORD_W(32), .BUS_W(4)) dut (
    .clk(clk), .reset(reset), .ch_data(ch_data), .ch_data_ready(ch_data_ready),
    .ch_last(ch_last), .tail_beats(tail_beats), .ch_capture(ch_capture),
    .qspi_data(qspi_data), .qspi_sending(qspi_sending), .qspi_ready(qspi_ready),
    .done(done), .busy(busy)
  );

  ordered_collector #(.NUM_CH(3), .WORD_W(32), .BUS_W(8)) dut3 (
    .clk(clk), .reset(reset), .ch_data(d3_data), .ch_data_ready(d3_ready),
    .ch_last(d3_last), .tail_beats(d3_tail), .ch_capture(d3_cap),
    .qspi_data(d3_q), .qspi_sending(d3_sending), .qspi_ready(d3_qready),
    .done(d3_done), .busy(d3_busy)
  );

  ordered_collector #(.NUM_CH(1), .WORD_W(32), .BUS_W(4)) dut1 (
    .clk(clk), .reset(reset), .ch_data(d1_data), .ch_data_ready(d1_ready),
    .ch_last(d1_last), .tail_beats(d1_tail), .ch_capture(d1_cap),
    .qspi_data(d1_q), .qspi_sending(d1_sending), .qspi_ready(d1_qready),
    .done(d1_done), .busy(d1_busy)
  );

  // Every comparison goes through here.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one cycle and land 1 time unit after the rising edge, where
  // outputs are sampled and the next inputs are driven.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a word on one lane of the two-lane instance.
  task automatic applyStimulus(input int lane, input logic [31:0] word, input logic last);
    ch_data[lane*32 +: 32] = word;
    ch_last[lane]          = last;
    ch_data_ready[lane]    = 1'b1;
  endtask

  // Follow one word through the two-lane instance starting at its first
  // beat. The lane that sees its capture drops ready straight away. For a
  // last word the done cycle and the return to idle are checked too.
  task automatic expectWord(input string tag, input logic [31:0] word,
                            input logic [1:0] cap, input int nbeats, input logic last);
    logic [31:0] w;
    w = word;
    for (int i = 0; i < nbeats; i++) begin
      checkOutput({tag, " sending"}, 64'(qspi_sending), 64'd1);
      checkOutput({tag, " data"}, 64'(qspi_data), 64'(w[31:28]));
      checkOutput({tag, " capture"}, 64'(ch_capture), (i == 0) ? 64'(cap) : 64'd0);
      if (i == 0) ch_data_ready = ch_data_ready & ~cap;
      w = w << 4;
      tick();
    end
    if (last) begin
      checkOutput({tag, " done"}, 64'(done), 64'd1);
      checkOutput({tag, " done sending"}, 64'(qspi_sending), 64'd0);
      checkOutput({tag, " done busy"}, 64'(busy), 64'd1);
      tick();
      checkOutput({tag, " done pulse"}, 64'(done), 64'd0);
      checkOutput({tag, " idle busy"}, 64'(busy), 64'd0);
    end
  endtask

  logic [3:0]  bp_exp  [11] = '{4'hB, 4'h4, 4'h3, 4'h3, 4'h3, 4'h3, 4'h5, 4'h2, 4'hB, 4'h9, 4'h3};
  logic        bp_rdy  [11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [7:0]  d3_exp  [16] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hA1, 8'hB2, 8'hC3, 8'hD4,
                                8'h55, 8'h66, 8'h77, 8'h88, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
  logic [31:0] d1_words [3] = '{32'h13579BDF, 32'h2468ACE0, 32'hFEDCBA98};

  initial begin
    logic [31:0] cur;

    // Reset held with every input of the main instance high
    reset         = 1'b1;
    ch_data       = {32'h12345678, 32'hB4352B93};
    ch_data_ready = 2'b11;
    ch_last       = 2'b11;
    tail_beats    = 4'hF;
    qspi_ready    = 1'b1;
    d3_data = '0; d3_ready = '0; d3_last = '0; d3_tail = '0; d3_qready = 1'b1;
    d1_data = '0; d1_ready = 1'b0; d1_last = 1'b0; d1_tail = '0; d1_qready = 1'b1;

    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("reset capture", 64'(ch_capture), 64'd0);
      checkOutput("reset data", 64'(qspi_data), 64'd0);
      checkOutput("reset sending", 64'(qspi_sending), 64'd0);
      checkOutput("reset done", 64'(done), 64'd0);
      checkOutput("reset busy", 64'(busy), 64'd0);
      checkOutput("reset d3 sending", 64'(d3_sending), 64'd0);
      checkOutput("reset d1 sending", 64'(d1_sending), 64'd0);
    end
    reset      = 1'b0;
    ch_last    = 2'b00;
    tail_beats = 4'd0;

    // Ordered burst: first load on the first edge after reset falls, lane 1
    // follows with no gap
    tick();
    expectWord("burst lane0", 32'hB4352B93, 2'b01, 8, 1'b0);
    expectWord("burst lane1", 32'h12345678, 2'b10, 8, 1'b0);
    checkOutput("burst end sending", 64'(qspi_sending), 64'd0);
    checkOutput("burst end busy", 64'(busy), 64'd0);

    // Order enforcement: lane 1 waits behind an absent lane 0
    applyStimulus(1, 32'hCAFEF00D, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("order hold sending", 64'(qspi_sending), 64'd0);
      checkOutput("order hold capture", 64'(ch_capture), 64'd0);
    end
    applyStimulus(0, 32'h0F1E2D3C, 1'b0);
    tick();
    expectWord("order lane0", 32'h0F1E2D3C, 2'b01, 8, 1'b0);
    expectWord("order lane1", 32'hCAFEF00D, 2'b10, 8, 1'b0);
    checkOutput("order end sending", 64'(qspi_sending), 64'd0);

    // Backpressure: three stall cycles on the third beat
    applyStimulus(0, 32'hB4352B93, 1'b0);
    tick();
    for (int i = 0; i < 11; i++) begin
      checkOutput("bp sending", 64'(qspi_sending), 64'd1);
      checkOutput("bp data", 64'(qspi_data), 64'(bp_exp[i]));
      checkOutput("bp capture", 64'(ch_capture), (i == 0) ? 64'd1 : 64'd0);
      if (i == 0) ch_data_ready[0] = 1'b0;
      qspi_ready = bp_rdy[i];
      tick();
    end
    qspi_ready = 1'b1;
    checkOutput("bp end sending", 64'(qspi_sending), 64'd0);

    // Reset in the middle of a lane 1 word discards it and re-arms lane 0
    applyStimulus(1, 32'h11223344, 1'b0);
    tick();
    checkOutput("midreset capture", 64'(ch_capture), 64'd2);
    ch_data_ready[1] = 1'b0;
    tick();
    tick();
    checkOutput("midreset beat3", 64'(qspi_data), 64'd2);
    reset = 1'b1;
    tick();
    checkOutput("midreset sending", 64'(qspi_sending), 64'd0);
    checkOutput("midreset data", 64'(qspi_data), 64'd0);
    checkOutput("midreset busy", 64'(busy), 64'd0);
    reset = 1'b0;
    applyStimulus(1, 32'h5A5A0FF0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("post reset lane1 ignored", 64'(qspi_sending), 64'd0);
      checkOutput("post reset capture", 64'(ch_capture), 64'd0);
    end

    // Tail words and done; lane 1 stays pending and must stay ignored
    tail_beats = 4'd2;
    applyStimulus(0, 32'hAB000000, 1'b1);
    tick();
    expectWord("tail2", 32'hAB000000, 2'b01, 2, 1'b1);
    checkOutput("after done sending", 64'(qspi_sending), 64'd0);
    checkOutput("after done capture", 64'(ch_capture), 64'd0);

    tail_beats = 4'd0;
    applyStimulus(0, 32'hA5C3E100, 1'b1);
    tick();
    expectWord("tail0", 32'hA5C3E100, 2'b01, 8, 1'b1);

    tail_beats = 4'd12;
    applyStimulus(0, 32'h3C3C3C3C, 1'b1);
    tick();
    expectWord("tail over", 32'h3C3C3C3C, 2'b01, 8, 1'b1);

    tail_beats = 4'd0;
    applyStimulus(0, 32'h87654321, 1'b0);
    tick();
    expectWord("resume lane0", 32'h87654321, 2'b01, 8, 1'b0);
    expectWord("resume lane1", 32'h5A5A0FF0, 2'b10, 8, 1'b0);
    checkOutput("resume end sending", 64'(qspi_sending), 64'd0);

    // Three lanes, byte bus: lanes 0,1,2 then lane 0 again with a new word
    d3_data  = {32'h55667788, 32'hA1B2C3D4, 32'h01020304};
    d3_ready = 3'b111;
    tick();
    for (int k = 0; k < 16; k++) begin
      checkOutput("n3 sending", 64'(d3_sending), 64'd1);
      checkOutput("n3 data", 64'(d3_q), 64'(d3_exp[k]));
      checkOutput("n3 capture", 64'(d3_cap),
                  (k == 0 || k == 12) ? 64'd1 : (k == 4) ? 64'd2 : (k == 8) ? 64'd4 : 64'd0);
      if (k == 0) d3_ready[0] = 1'b0;
      if (k == 1) begin
        d3_data[31:0] = 32'hDEADBEEF;
        d3_ready[0]   = 1'b1;
      end
      if (k == 4) d3_ready[1] = 1'b0;
      if (k == 8) d3_ready[2] = 1'b0;
      if (k == 12) d3_ready[0] = 1'b0;
      tick();
    end
    checkOutput("n3 end sending", 64'(d3_sending), 64'd0);

    // Single lane with ready held high: one capture per word, each word new
    d1_data  = d1_words[0];
    d1_ready = 1'b1;
    cur      = '0;
    tick();
    for (int k = 0; k < 24; k++) begin
      if (k % 8 == 0) cur = d1_words[k / 8];
      checkOutput("n1 sending", 64'(d1_sending), 64'd1);
      checkOutput("n1 data", 64'(d1_q), 64'(cur[31:28]));
      checkOutput("n1 capture", 64'(d1_cap), (k % 8 == 0) ? 64'd1 : 64'd0);
      cur = cur << 4;
      if (k == 0) d1_data = d1_words[1];
      if (k == 8) d1_data = d1_words[2];
      if (k == 16) d1_ready = 1'b0;
      tick();
    end
    checkOutput("n1 end sending", 64'(d1_sending), 64'd0);
    checkOutput("n1 end capture", 64'(d1_cap), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
